// File: rtl/pipe_pkg.sv
// pipe_pkg: definitions shared by the pipeline stage register and its storage
// slots.
//   NOP_INSTR    - instruction word held by an empty slot
//   A3_W_DEFAULT - default width of the destination-register field
//   occ_t        - occupancy of the two-entry skid variant
package pipe_pkg;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
  localparam int          A3_W_DEFAULT = 5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    MAIN  = 2'd1,
    FULL  = 2'd2
  } occ_t;

endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one storage entry of a pipeline stage (valid bit plus fields).
// Ports:
//   clk, reset (async, active-low)
//   load    - capture d_* and set valid
//   clear   - drop the entry; takes priority over load
//   d_data, d_instr, d_pc, d_a3 - fields to capture
//   valid, data, instr, pc, a3  - held entry
// Every field is zeroed whenever the entry is dropped, so an invalid slot
// always reads as a NOP with no destination register.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int A3_W   = A3_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] d_data,
  input  logic [31:0]       d_instr,
  input  logic [31:0]       d_pc,
  input  logic [A3_W-1:0]   d_a3,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [31:0]       instr,
  output logic [31:0]       pc,
  output logic [A3_W-1:0]   a3
);

  // Entry register; reset and clear both return it to the bubble encoding.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      data  <= '0;
      instr <= NOP_INSTR;
      pc    <= '0;
      a3    <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      data  <= '0;
      instr <= NOP_INSTR;
      pc    <= '0;
      a3    <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= d_data;
      instr <= d_instr;
      pc    <= d_pc;
      a3    <= d_a3;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register with optional skid
// entry and a bubble counter.
// Parameters:
//   DATA_W - payload width, A3_W - destination-register width,
//   SKID   - 1: main + skid entries, registered in_ready; 0: single entry,
//   CNT_W  - bubble counter width
// Ports:
//   clk, reset (async, active-low)
//   in_valid/in_ready, in_data, in_instr, in_pc, in_a3 - upstream side
//   out_valid/out_ready, out_data, out_instr, out_pc, out_a3 - downstream side
//   flush   - kill every held instruction (and any same-cycle input)
//   clr_cnt - zero the bubble counter
//   bubble_cnt - saturating count of edges with out_valid low
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int A3_W   = A3_W_DEFAULT,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [31:0]       in_instr,
  input  logic [31:0]       in_pc,
  input  logic [A3_W-1:0]   in_a3,
  input  logic              flush,
  input  logic              clr_cnt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [31:0]       out_instr,
  output logic [31:0]       out_pc,
  output logic [A3_W-1:0]   out_a3,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              in_xfer;
  logic              out_xfer;
  logic              main_load;
  logic              main_clear;
  logic [DATA_W-1:0] main_d_data;
  logic [31:0]       main_d_instr;
  logic [31:0]       main_d_pc;
  logic [A3_W-1:0]   main_d_a3;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  // The main slot drives the outputs directly; it zeroes its own fields when
  // empty, so bubbles never look like a real instruction to forwarding logic.
  pipe_slot #(
    .DATA_W (DATA_W),
    .A3_W   (A3_W)
  ) u_main (
    .clk     (clk),
    .reset   (reset),
    .load    (main_load),
    .clear   (main_clear),
    .d_data  (main_d_data),
    .d_instr (main_d_instr),
    .d_pc    (main_d_pc),
    .d_a3    (main_d_a3),
    .valid   (out_valid),
    .data    (out_data),
    .instr   (out_instr),
    .pc      (out_pc),
    .a3      (out_a3)
  );

  if (SKID != 0) begin : g_skid
    occ_t              occ;
    occ_t              occ_nxt;
    logic              ready_q;
    logic              from_skid;
    logic              skid_load;
    logic              skid_clear;
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [31:0]       skid_instr;
    logic [31:0]       skid_pc;
    logic [A3_W-1:0]   skid_a3;

    pipe_slot #(
      .DATA_W (DATA_W),
      .A3_W   (A3_W)
    ) u_skid (
      .clk     (clk),
      .reset   (reset),
      .load    (skid_load),
      .clear   (skid_clear),
      .d_data  (in_data),
      .d_instr (in_instr),
      .d_pc    (in_pc),
      .d_a3    (in_a3),
      .valid   (skid_valid),
      .data    (skid_data),
      .instr   (skid_instr),
      .pc      (skid_pc),
      .a3      (skid_a3)
    );

    // Occupancy register. in_ready is registered from the next occupancy so
    // it never depends combinationally on out_ready; it stays low in reset
    // and rises on the first edge afterwards.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        occ     <= EMPTY;
        ready_q <= 1'b0;
      end else begin
        occ     <= occ_nxt;
        ready_q <= (occ_nxt != FULL);
      end
    end

    // Next occupancy and slot controls. Flush wins over everything, including
    // a same-cycle input transfer.
    always_comb begin
      occ_nxt    = occ;
      main_load  = 1'b0;
      main_clear = 1'b0;
      from_skid  = 1'b0;
      skid_load  = 1'b0;
      skid_clear = 1'b0;
      if (flush) begin
        occ_nxt    = EMPTY;
        main_clear = 1'b1;
        skid_clear = 1'b1;
      end else begin
        unique case (occ)
          EMPTY: begin
            if (in_xfer) begin
              main_load = 1'b1;
              occ_nxt   = MAIN;
            end
          end
          MAIN: begin
            if (in_xfer && out_xfer) begin
              main_load = 1'b1;
            end else if (in_xfer) begin
              skid_load = 1'b1;
              occ_nxt   = FULL;
            end else if (out_xfer) begin
              main_clear = 1'b1;
              occ_nxt    = EMPTY;
            end
          end
          FULL: begin
            if (out_xfer) begin
              main_load  = 1'b1;
              from_skid  = 1'b1;
              skid_clear = 1'b1;
              occ_nxt    = MAIN;
            end
          end
          default: begin
            occ_nxt    = EMPTY;
            main_clear = 1'b1;
            skid_clear = 1'b1;
          end
        endcase
      end
    end

    assign in_ready     = ready_q;
    assign main_d_data  = from_skid ? skid_data  : in_data;
    assign main_d_instr = from_skid ? skid_instr : in_instr;
    assign main_d_pc    = from_skid ? skid_pc    : in_pc;
    assign main_d_a3    = from_skid ? skid_a3    : in_a3;
  end else begin : g_single
    logic alive_q;

    // Holds in_ready low while in reset and until the first edge after it.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        alive_q <= 1'b0;
      end else begin
        alive_q <= 1'b1;
      end
    end

    assign in_ready     = alive_q && (!out_valid || out_ready);
    assign main_load    = in_xfer && !flush;
    assign main_clear   = flush || (out_xfer && !in_xfer);
    assign main_d_data  = in_data;
    assign main_d_instr = in_instr;
    assign main_d_pc    = in_pc;
    assign main_d_a3    = in_a3;
  end

  // Bubble counter: clear beats increment, and the count sticks at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bubble_cnt <= '0;
    end else if (clr_cnt) begin
      bubble_cnt <= '0;
    end else if (!out_valid && (bubble_cnt != {CNT_W{1'b1}})) begin
      bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed bench for pipe_stage_reg. Three instances share
// one stimulus: dut1 (SKID=1), dut0 (SKID=0) and dutc (SKID=1, CNT_W=2).
module tb_pipe_stage_reg;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_data;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [4:0]  in_a3;
  logic        flush;
  logic        clr_cnt;
  logic        out_ready;

  logic        o1_in_ready, o1_valid;
  logic [31:0] o1_data, o1_instr, o1_pc;
  logic [4:0]  o1_a3;
  logic [15:0] o1_bubble;

  logic        o0_in_ready, o0_valid;
  logic [31:0] o0_data, o0_instr, o0_pc;
  logic [4:0]  o0_a3;
  logic [15:0] o0_bubble;

  logic        oc_in_ready, oc_valid;
  logic [31:0] oc_data, oc_instr, oc_pc;
  logic [4:0]  oc_a3;
  logic [1:0]  oc_bubble;

  int total;
  int passed;

  pipe_stage_reg dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(o1_in_ready),
    .in_data(in_data), .in_instr(in_instr), .in_pc(in_pc), .in_a3(in_a3),
    .flush(flush), .clr_cnt(clr_cnt), .out_valid(o1_valid), .out_ready(out_ready),
    .out_data(o1_data), .out_instr(o1_instr), .out_pc(o1_pc), .out_a3(o1_a3),
    .bubble_cnt(o1_bubble)
  );

  pipe_stage_reg #(.SKID(0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(o0_in_ready),
    .in_data(in_data), .in_instr(in_instr), .in_pc(in_pc), .in_a3(in_a3),
    .flush(flush), .clr_cnt(clr_cnt), .out_valid(o0_valid), .out_ready(out_ready),
    .out_data(o0_data), .out_instr(o0_instr), .out_pc(o0_pc), .out_a3(o0_a3),
    .bubble_cnt(o0_bubble)
  );

  pipe_stage_reg #(.CNT_W(2)) dutc (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(oc_in_ready),
    .in_data(in_data), .in_instr(in_instr), .in_pc(in_pc), .in_a3(in_a3),
    .flush(flush), .clr_cnt(clr_cnt), .out_valid(oc_valid), .out_ready(out_ready),
    .out_data(oc_data), .out_instr(oc_instr), .out_pc(oc_pc), .out_a3(oc_a3),
    .bubble_cnt(oc_bubble)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout want $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] a3);
    in_valid = v;
    in_pc    = pc;
    in_a3    = a3;
    in_data  = pc ^ 32'h5a5a_0000;
    in_instr = {pc[15:0], 16'h0013};
  endtask

  // Holds reset for two edges and releases it 1 time unit after an edge.
  task automatic do_reset();
    reset     = 1'b0;
    flush     = 1'b0;
    clr_cnt   = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 32'h0, 5'd0);
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    flush     = 1'b0;
    clr_cnt   = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 32'h3000, 5'd8);
    tick();
    tick();
    total++; if (o1_valid !== 1'b0) $display("[TB] FAIL rst_valid: got %b want 0", o1_valid); else passed++;
    total++; if (o1_in_ready !== 1'b0) $display("[TB] FAIL rst_in_ready1: got %b want 0", o1_in_ready); else passed++;
    total++; if (o0_in_ready !== 1'b0) $display("[TB] FAIL rst_in_ready0: got %b want 0", o0_in_ready); else passed++;
    total++; if (o1_pc !== 32'h0) $display("[TB] FAIL rst_pc: got %h want 0", o1_pc); else passed++;
    total++; if (o1_bubble !== 16'd0) $display("[TB] FAIL rst_bubble: got %0d want 0", o1_bubble); else passed++;
    drive(1'b0, 32'h0, 5'd0);
    reset = 1'b1;
    #1;
    total++; if (o1_in_ready !== 1'b0) $display("[TB] FAIL rel_in_ready_pre: got %b want 0", o1_in_ready); else passed++;
    tick();
    total++; if (o1_in_ready !== 1'b1) $display("[TB] FAIL rel_in_ready1: got %b want 1", o1_in_ready); else passed++;
    total++; if (o0_in_ready !== 1'b1) $display("[TB] FAIL rel_in_ready0: got %b want 1", o0_in_ready); else passed++;
    total++; if (o1_bubble !== 16'd1) $display("[TB] FAIL rel_bubble: got %0d want 1", o1_bubble); else passed++;
  endtask

  task automatic test_single();
    do_reset();
    tick();
    out_ready = 1'b1;
    drive(1'b1, 32'h3000, 5'd8);
    tick();
    drive(1'b0, 32'h0, 5'd0);
    total++; if (o1_valid !== 1'b1) $display("[TB] FAIL single_valid: got %b want 1", o1_valid); else passed++;
    total++; if (o1_pc !== 32'h3000) $display("[TB] FAIL single_pc: got %h want 3000", o1_pc); else passed++;
    total++; if (o1_a3 !== 5'd8) $display("[TB] FAIL single_a3: got %0d want 8", o1_a3); else passed++;
    total++; if (o1_data !== 32'h5a5a_3000) $display("[TB] FAIL single_data: got %h want 5a5a3000", o1_data); else passed++;
    total++; if (o1_instr !== 32'h3000_0013) $display("[TB] FAIL single_instr: got %h want 30000013", o1_instr); else passed++;
    total++; if (o0_pc !== 32'h3000) $display("[TB] FAIL single_pc0: got %h want 3000", o0_pc); else passed++;
    tick();
    total++; if (o1_valid !== 1'b0) $display("[TB] FAIL single_drain_valid: got %b want 0", o1_valid); else passed++;
    total++; if (o1_a3 !== 5'd0) $display("[TB] FAIL single_drain_a3: got %0d want 0", o1_a3); else passed++;
    total++; if (o1_pc !== 32'h0) $display("[TB] FAIL single_drain_pc: got %h want 0", o1_pc); else passed++;
    total++; if (o1_data !== 32'h0) $display("[TB] FAIL single_drain_data: got %h want 0", o1_data); else passed++;
  endtask

  task automatic test_skid();
    out_ready = 1'b0;
    drive(1'b1, 32'h3000, 5'd1);
    tick();
    total++; if (o1_in_ready !== 1'b1) $display("[TB] FAIL skid_main_ready: got %b want 1", o1_in_ready); else passed++;
    drive(1'b1, 32'h3004, 5'd2);
    tick();
    total++; if (o1_in_ready !== 1'b0) $display("[TB] FAIL skid_full_ready: got %b want 0", o1_in_ready); else passed++;
    total++; if (o1_pc !== 32'h3000) $display("[TB] FAIL skid_full_pc: got %h want 3000", o1_pc); else passed++;
    drive(1'b1, 32'h3008, 5'd3);
    tick();
    total++; if (o1_pc !== 32'h3000) $display("[TB] FAIL skid_stall_pc: got %h want 3000", o1_pc); else passed++;
    total++; if (o1_a3 !== 5'd1) $display("[TB] FAIL skid_stall_a3: got %0d want 1", o1_a3); else passed++;
    total++; if (o1_in_ready !== 1'b0) $display("[TB] FAIL skid_stall_ready: got %b want 0", o1_in_ready); else passed++;
    drive(1'b0, 32'h0, 5'd0);
    out_ready = 1'b1;
    tick();
    total++; if (o1_pc !== 32'h3004) $display("[TB] FAIL skid_second_pc: got %h want 3004", o1_pc); else passed++;
    total++; if (o1_valid !== 1'b1) $display("[TB] FAIL skid_second_valid: got %b want 1", o1_valid); else passed++;
    total++; if (o1_in_ready !== 1'b1) $display("[TB] FAIL skid_ready_back: got %b want 1", o1_in_ready); else passed++;
    tick();
    total++; if (o1_valid !== 1'b0) $display("[TB] FAIL skid_empty_valid: got %b want 0", o1_valid); else passed++;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 32'h3004, 5'd2);
    tick();
    total++; if (o1_pc !== 32'h3004) $display("[TB] FAIL flush_pre_pc: got %h want 3004", o1_pc); else passed++;
    drive(1'b1, 32'h3008, 5'd3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 5'd0);
    out_ready = 1'b1;
    total++; if (o1_valid !== 1'b0) $display("[TB] FAIL flush_valid: got %b want 0", o1_valid); else passed++;
    total++; if (o1_in_ready !== 1'b1) $display("[TB] FAIL flush_ready: got %b want 1", o1_in_ready); else passed++;
    tick();
    total++; if (o1_valid !== 1'b0) $display("[TB] FAIL flush_no3008_valid: got %b want 0", o1_valid); else passed++;
    total++; if (o1_pc !== 32'h0) $display("[TB] FAIL flush_no3008_pc: got %h want 0", o1_pc); else passed++;
  endtask

  task automatic test_single_entry();
    do_reset();
    tick();
    out_ready = 1'b1;
    drive(1'b1, 32'h3000, 5'd4);
    tick();
    total++; if (o0_pc !== 32'h3000) $display("[TB] FAIL s0_first_pc: got %h want 3000", o0_pc); else passed++;
    out_ready = 1'b0;
    drive(1'b1, 32'h3004, 5'd5);
    #1;
    total++; if (o0_in_ready !== 1'b0) $display("[TB] FAIL s0_stall_ready: got %b want 0", o0_in_ready); else passed++;
    tick();
    total++; if (o0_pc !== 32'h3000) $display("[TB] FAIL s0_stall_pc: got %h want 3000", o0_pc); else passed++;
    total++; if (o0_a3 !== 5'd4) $display("[TB] FAIL s0_stall_a3: got %0d want 4", o0_a3); else passed++;
    out_ready = 1'b1;
    #1;
    total++; if (o0_in_ready !== 1'b1) $display("[TB] FAIL s0_resume_ready: got %b want 1", o0_in_ready); else passed++;
    tick();
    total++; if (o0_pc !== 32'h3004) $display("[TB] FAIL s0_second_pc: got %h want 3004", o0_pc); else passed++;
    drive(1'b1, 32'h3008, 5'd6);
    tick();
    drive(1'b0, 32'h0, 5'd0);
    total++; if (o0_pc !== 32'h3008) $display("[TB] FAIL s0_third_pc: got %h want 3008", o0_pc); else passed++;
    tick();
    total++; if (o0_valid !== 1'b0) $display("[TB] FAIL s0_drain_valid: got %b want 0", o0_valid); else passed++;
  endtask

  task automatic test_bubble();
    do_reset();
    repeat (5) tick();
    total++; if (o1_bubble !== 16'd5) $display("[TB] FAIL bub_idle5: got %0d want 5", o1_bubble); else passed++;
    total++; if (oc_bubble !== 2'd3) $display("[TB] FAIL bub_sat5: got %0d want 3", oc_bubble); else passed++;
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    total++; if (o1_bubble !== 16'd0) $display("[TB] FAIL bub_clr: got %0d want 0", o1_bubble); else passed++;
    total++; if (oc_bubble !== 2'd0) $display("[TB] FAIL bub_clr_c: got %0d want 0", oc_bubble); else passed++;
    repeat (6) tick();
    total++; if (o1_bubble !== 16'd6) $display("[TB] FAIL bub_idle6: got %0d want 6", o1_bubble); else passed++;
    total++; if (oc_bubble !== 2'd3) $display("[TB] FAIL bub_sat6: got %0d want 3", oc_bubble); else passed++;
  endtask

  task automatic test_async_reset();
    do_reset();
    tick();
    out_ready = 1'b0;
    drive(1'b1, 32'h3000, 5'd1);
    tick();
    drive(1'b1, 32'h3004, 5'd2);
    tick();
    drive(1'b0, 32'h0, 5'd0);
    total++; if (o1_in_ready !== 1'b0) $display("[TB] FAIL ar_full_ready: got %b want 0", o1_in_ready); else passed++;
    total++; if (o1_bubble !== 16'd2) $display("[TB] FAIL ar_pre_bubble: got %0d want 2", o1_bubble); else passed++;
    #2;
    reset = 1'b0;
    #1;
    total++; if (o1_valid !== 1'b0) $display("[TB] FAIL ar_valid: got %b want 0", o1_valid); else passed++;
    total++; if (o1_bubble !== 16'd0) $display("[TB] FAIL ar_bubble: got %0d want 0", o1_bubble); else passed++;
    total++; if (o1_pc !== 32'h0) $display("[TB] FAIL ar_pc: got %h want 0", o1_pc); else passed++;
    total++; if (o1_in_ready !== 1'b0) $display("[TB] FAIL ar_ready: got %b want 0", o1_in_ready); else passed++;
    tick();
    reset = 1'b1;
    tick();
    total++; if (o1_valid !== 1'b0) $display("[TB] FAIL ar_after_valid: got %b want 0", o1_valid); else passed++;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    test_reset();
    test_single();
    test_skid();
    test_flush();
    test_single_entry();
    test_bubble();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 32: width of the generic payload (e.g. V2/AO data).
REQ-002 Parameter A3_W, default 5: width of the destination-register field.
REQ-003 Parameter SKID, default 1: 1 selects a 2-entry skid buffer; 0 selects a single-entry register.
REQ-004 Parameter CNT_W, default 16: width of the bubble counter.
REQ-005 clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 in_valid  in  1  upstream stage presents a valid instruction.
REQ-008 in_ready  out  1  stage can accept the presented instruction this cycle.
REQ-009 in_data  in  DATA_W  payload.
REQ-010 in_instr  in  32  instruction word.
REQ-011 in_pc  in  32  instruction PC.
REQ-012 in_a3  in  A3_W  destination register number; 0 means no write.
REQ-013 flush  in  1  synchronous kill of all held instructions.
REQ-014 clr_cnt  in  1  synchronous clear of the bubble counter.
REQ-015 out_valid  out  1  held instruction valid.
REQ-016 out_ready  in  1  downstream accepts this cycle.
REQ-017 out_data, out_instr, out_pc, out_a3  out  DATA_W/32/32/A3_W  held fields.
REQ-018 bubble_cnt  out  CNT_W  count of cycles with out_valid low.

Function
REQ-019 An input transfer SHALL occur when in_valid && in_ready; an output transfer SHALL occur when out_valid && out_ready.
REQ-020 Latency from input transfer to out_valid SHALL be exactly 1 cycle when the stage is empty.
REQ-021 When out_valid is 0, out_instr, out_pc, out_data and out_a3 SHALL all read 0, so forwarding logic never matches a bubble.
REQ-022 SKID=1: in_ready SHALL be a registered signal equal to "skid entry empty," with no combinational path from out_ready.
REQ-023 SKID=1 occupancy SHALL be one of EMPTY, MAIN, or FULL (main + skid).
- EMPTY -> MAIN on an input transfer.
- MAIN stays MAIN on simultaneous input and output transfers.
- MAIN -> EMPTY on an output transfer only.
- MAIN -> FULL on an input transfer without an output transfer.
- FULL -> MAIN on an output transfer; the skid entry moves into main on the same edge.
REQ-024 In FULL, in_ready SHALL be 0 and no input is accepted.
REQ-025 SKID=0: in_ready SHALL be !out_valid || out_ready (combinational).
- Main is loaded on an input transfer.
- Main is emptied on an output transfer with no input transfer.
REQ-026 Data order SHALL be strictly FIFO; no instruction is duplicated or lost except by flush.
REQ-027 flush SHALL clear all entries on the next edge and take priority over a same-cycle input transfer; that input is discarded.
REQ-028 After a flush, in_ready SHALL be 1 in the following cycle.
REQ-029 bubble_cnt SHALL increment by 1 on each edge where out_valid is 0.
- It saturates at all-ones.
- clr_cnt forces it to 0 and takes priority over increment.
REQ-030 Held fields SHALL NOT change while out_valid && !out_ready, except under flush.

Reset
REQ-031 Asserting reset (low) SHALL immediately, without a clock, clear all entries and set bubble_cnt to 0.
REQ-032 While reset is asserted, out_valid SHALL be 0, all out_* fields 0, and in_ready 0.
REQ-033 in_ready SHALL rise on the first clk edge after reset deasserts.
REQ-034 Reset asserted mid-transfer SHALL discard all held instructions with no partial update.

Structure
REQ-035 A shared package pipe_pkg SHALL hold:
- the NOP instruction constant 32'h0000_0000;
- the default A3_W;
- the occupancy state typedef {EMPTY, MAIN, FULL}.
REQ-036 Each storage entry SHALL be one instance of sub-module pipe_slot (valid bit + fields, load/clear controls).
- SKID=1 uses two instances.
- SKID=0 uses one instance.
REQ-037 A single clock domain SHALL be used; the block SHALL contain no latches.

Verification
REQ-038 Directed scenarios the bench SHALL cover:
- Reset release, SKID=1, out_ready=1: in_valid=1, in_pc=32'h3000, in_a3=5'd8 for one cycle -> next cycle out_valid=1, out_pc=32'h3000, out_a3=8; following cycle out_valid=0, out_a3=0.
- SKID=1, out_ready=0: send PC 3000, then 3004 -> state FULL, in_ready=0; raise out_ready -> outputs 3000 then 3004 in order, in_ready returns to 1.
- Flush in the same cycle as an input transfer (PC 3008) with MAIN holding 3004 -> next cycle out_valid=0, in_ready=1, and 3008 never appears.
- SKID=0, out_ready toggling 1,0,1 with continuous input PCs 3000,3004,3008 -> each PC appears exactly once, in order, and is held stable while stalled.
- Idle 5 cycles after reset -> bubble_cnt=5; pulse clr_cnt -> 0.
- With CNT_W=2, run 6 idle cycles -> bubble_cnt saturates at 3.
- Assert reset low asynchronously mid-cycle while FULL -> out_valid=0 and bubble_cnt=0 immediately, before the next edge.
